// File: rtl/spi_block_sequencer_if.sv
// Block-request and byte-engine handshake bundle for spi_block_sequencer.
// master: sequencer side; slave: AES core / SPI byte engine side.
interface spi_block_sequencer_if #(
  parameter int unsigned NBYTES = 16
);
  logic                  start;
  logic [8*NBYTES-1:0]   tx_block;
  logic [8*NBYTES-1:0]   rx_block;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  cs_n;
  logic                  byte_start;
  logic [7:0]            byte_tx;
  logic [7:0]            byte_rx;
  logic                  byte_done;

  modport master (
    input  start, tx_block, byte_rx, byte_done,
    output rx_block, busy, done, err, cs_n, byte_start, byte_tx
  );

  modport slave (
    output start, tx_block, byte_rx, byte_done,
    input  rx_block, busy, done, err, cs_n, byte_start, byte_tx
  );
endinterface

// File: rtl/spi_block_sequencer.sv
// Moves one NBYTES-byte block per start over a byte-level SPI start/done engine.
// Optional per-byte watchdog is enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_block_sequencer #(
  parameter int unsigned NBYTES         = 16,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_block_sequencer_if.master bus
);
  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned CntW = $clog2(NBYTES + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(NBYTES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StGap    = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [W-1:0]    tx_q, tx_d;
  logic [W-1:0]    rx_q, rx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            err_q, err_d;
  logic            wd_expire;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle if the byte still has not completed.
  assign wd_expire = (state_q == StWait) && !bus.byte_done && (wd_q == WdLast);

  always_comb begin
    wd_d = wd_q;
    if (state_q == StLoad) begin
      wd_d = '0;
    end else if (state_q == StWait && !bus.byte_done && !wd_expire) begin
      wd_d = wd_q + WdW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expire      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          tx_d    = bus.tx_block;
          rx_d    = '0;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        gap_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.byte_done) begin
          rx_d  = (rx_q << 8) | W'(bus.byte_rx);
          tx_d  = tx_q << 8;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StFinish;
          end else if (GAP_CYCLES == 0) begin
            state_d = StLoad;
          end else begin
            state_d = StGap;
          end
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StLoad;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  // Chip select spans LOAD..GAP; it is released as FINISH is entered.
  assign bus.cs_n       = !((state_q == StLoad) || (state_q == StWait) || (state_q == StGap));
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StFinish);
  assign bus.byte_start = (state_q == StLoad);
  assign bus.byte_tx    = tx_q[W-1 -: 8];
  assign bus.rx_block   = rx_q;
  assign bus.err        = err_q;

endmodule

// File: doc/spi_block_sequencer.md
Name: spi_block_sequencer

Overview:
Sequences a byte-level SPI main engine to move one full AES block (default 16 bytes) per request. It latches a 128-bit transmit block, issues one byte transfer per slot over a start/done handshake, and holds chip select low for the whole burst. Received bytes are assembled into a 128-bit receive block. It sits between the AES core and the SPI byte engine.

Parameters:
NBYTES, 16, bytes per block transfer (>=1); data widths are 8*NBYTES.
GAP_CYCLES, 2, idle cycles between byte_done and the next byte_start (0 allowed).
TIMEOUT_CYCLES, 1024, watchdog limit per byte; used only with SPI_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request a block transfer; sampled only in IDLE.
tx_block  in  8*NBYTES  block to send; latched when start is accepted.
rx_block  out  8*NBYTES  assembled received block; valid when done pulses.
busy  out  1  high from the cycle after start acceptance through FINISH.
done  out  1  one-cycle pulse: block complete.
err  out  1  one-cycle pulse: byte timeout (constant 0 without the macro).
cs_n  out  1  block-level chip select, active low.
byte_start  out  1  one-cycle pulse launching one byte on the SPI engine.
byte_tx  out  8  byte to send; stable from byte_start until byte_done.
byte_rx  in  8  byte received; sampled when byte_done is high.
byte_done  in  1  byte engine completion strobe.

Behaviour:
- Reset (sync): state IDLE; cs_n=1, busy=0, done=0, err=0, byte_start=0, byte_tx=0, rx_block=0, byte counter=0, gap counter=0.
- States: IDLE, LOAD, WAIT, GAP, FINISH.
- IDLE: start=1 -> latch tx_block into a shift register, clear byte counter, go to LOAD. start while not IDLE is ignored and not queued.
- LOAD (1 cycle): cs_n=0, busy=1, byte_start=1, byte_tx = current MSB byte of the shift register. Go to WAIT. byte_done in LOAD is ignored.
- WAIT: byte_start=0. On byte_done=1: rx_block <= {rx_block[8*NBYTES-9:0], byte_rx}; shift the tx register left by 8; increment the counter. If the counter reaches NBYTES, go to FINISH. Else go to GAP, or directly to LOAD if GAP_CYCLES=0.
- GAP: stay exactly GAP_CYCLES cycles with cs_n held 0, then go to LOAD.
- FINISH (1 cycle): done=1, cs_n=1, busy=0 on exit; rx_block holds its value until the next accepted start. Next state IDLE. start in FINISH is ignored.
- Byte order: tx byte 0 = tx_block[8*NBYTES-1:8*NBYTES-8] is sent first. The first received byte ends in rx_block MSB.
- Latency: with a byte engine answering K cycles after byte_start, done pulses at NBYTES*(K+1) + (NBYTES-1)*GAP_CYCLES + 1 cycles after the start-accept edge.
- byte_done outside WAIT is ignored; no extra byte is captured.
- rst mid-burst: immediate return to IDLE, cs_n=1 the next cycle, partial rx_block cleared, no done pulse.
- Counter width: $clog2(NBYTES+1); no wrap within a burst.

Optional Feature:
SPI_SEQ_TIMEOUT_EN
- Defined: a watchdog counts cycles in WAIT. When it reaches TIMEOUT_CYCLES without byte_done, the block pulses err for one cycle, sets cs_n=1, does not pulse done, keeps rx_block partial, and returns to IDLE. The watchdog clears on every LOAD.
- Not defined: no watchdog logic; err tied 0; WAIT blocks indefinitely.

Test Plan:
1. Reset, then a byte-engine model echoing byte_tx^8'hFF after K=10 cycles; start with tx_block=128'h000102...0F -> 16 byte_start pulses with byte_tx 00..0F in order; rx_block=128'hFFFEFD...F0; done pulses once at cycle 16*11+15*2+1=207; cs_n low continuously between the first LOAD and FINISH.
2. GAP_CYCLES=0, NBYTES=2, tx=16'hA55A -> byte_tx A5 then 5A; next byte_start one cycle after the first byte_done.
3. start held high during the burst and in FINISH -> exactly one burst; a second burst only after IDLE is re-entered.
4. Spurious byte_done in LOAD and in GAP -> rx_block and the counter are unchanged; total bytes still 16.
5. rst asserted after byte 5 -> next cycle cs_n=1, busy=0, rx_block=0, no done; a new start runs a full 16-byte burst.
6. SPI_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=50 and an engine that never returns byte 3 -> err pulse 50 cycles into WAIT, cs_n=1, no done, state IDLE.
